pending_encoder8x3: RTL and testbench
=====================================

PENDING_ENCODER8X3 -- requirements
Module: pending_encoder8x3

Interface
REQ-001 Parameters: none; request width fixed at 8 and index width fixed at 3.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Enable  input  1  capture/grant enable.
REQ-005 req  input  8  request lines, one bit per source; sampled every rising edge.
REQ-006 ack  input  1  consumer acknowledges the presented index.
REQ-007 idx  output  3  encoded index of the granted source, registered.
REQ-008 valid  output  1  idx holds a grant awaiting ack, registered.
REQ-009 pending  output  8  current pending-request register.

Function
REQ-010 Capture: when Enable=1, each rising edge SHALL set pending[i] for every req[i]=1; when Enable=0, req SHALL be ignored and pending SHALL hold.
REQ-011 FSM states SHALL be IDLE and GRANT only.
REQ-012 IDLE: if Enable=1 and pending!=0 at an edge, FSM SHALL load idx with the selected index, set valid=1 and go to GRANT at that edge; otherwise it SHALL stay in IDLE with valid=0.
REQ-013 Selection without ROUND_ROBIN_EN SHALL be fixed priority: lowest set bit of pending wins.
REQ-014 Latency: req[i] high before edge k with pending=0 and FSM in IDLE SHALL give pending[i]=1 after edge k and valid=1, idx=i after edge k+1.
REQ-015 GRANT: idx and valid SHALL stay constant until ack=1 is sampled.
REQ-016 GRANT with ack=1 at an edge SHALL clear pending[idx], drive valid=0 and return to IDLE at that edge; the next grant appears no earlier than one edge later.
REQ-017 Simultaneous ack clear and req[idx]=1 capture on the same bit SHALL leave that bit set.
REQ-018 ack SHALL be ignored in IDLE.
REQ-019 Enable=0 in GRANT SHALL NOT abort the grant; ack still completes it. No new grant SHALL start while Enable=0.
REQ-020 idx SHALL keep its last value while valid=0.

Reset
REQ-021 rst_n=0 SHALL immediately force pending=8'h00, idx=3'd0, valid=0, FSM=IDLE and round-robin pointer=3'd7, independent of clk.
REQ-022 Reset asserted mid-GRANT SHALL discard the grant and all pending bits.
REQ-023 After rst_n deasserts, the first capture SHALL occur at the next rising edge.

Configuration
REQ-024 Macro ROUND_ROBIN_EN defined: selection SHALL search from (last granted index + 1) mod 8 upward with wrap-around 7->0; the pointer SHALL update to idx on each ack completion. Pointer reset 7 makes the first search start at 0.
REQ-025 Macro ROUND_ROBIN_EN undefined: fixed priority per REQ-013; no pointer register SHALL be present.

Verification
REQ-026 req=8'hA0 for one cycle, Enable=1 -> valid=1, idx=5 two edges later; ack -> pending=8'h80; next grant idx=7.
REQ-027 Grant idx=3 held, ack=1 with req=8'h08 in the same cycle -> pending[3]=1 remains; idx=3 re-granted.
REQ-028 Enable=0, req=8'hFF for 4 cycles -> pending=8'h00 and valid=0 throughout.
REQ-029 req=8'h81 held high, ack every grant -> without ROUND_ROBIN_EN idx=0,0,0,...; with ROUND_ROBIN_EN idx=0,7,0,7.
REQ-030 rst_n pulsed low between clock edges during GRANT idx=6 -> valid=0, idx=0, pending=8'h00 before the next edge.
REQ-031 ack=1 for 3 cycles in IDLE with pending=8'h00, then req=8'h04 -> grant idx=2 unaffected by the earlier ack.

Source files
------------

// File: rtl/pending_encoder8x3.sv
// Pending-request encoder: latches 8 request lines into a pending register and
// grants one index at a time until acknowledged. Define ROUND_ROBIN_EN for rotating priority.
module pending_encoder8x3 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Enable,
    input  logic [7:0] req,
    input  logic       ack,
    output logic [2:0] idx,
    output logic       valid,
    output logic [7:0] pending
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state, state_nxt;
    logic [2:0] idx_nxt;
    logic       valid_nxt;
    logic [7:0] pending_nxt;
    logic [7:0] clr;
    logic [2:0] sel;

`ifdef ROUND_ROBIN_EN
    logic [2:0] ptr, ptr_nxt;
    logic [2:0] cand;

    // Walk from the farthest candidate to the nearest so the closest set bit
    // after ptr is the last assignment; k=8 wraps back onto ptr itself.
    always_comb begin
        sel  = '0;
        cand = '0;
        for (int unsigned k = 8; k > 0; k--) begin
            cand = ptr + 3'(k);
            if (pending[cand]) sel = cand;
        end
    end
`else
    always_comb begin
        sel = '0;
        for (int unsigned k = 8; k > 0; k--) begin
            if (pending[k-1]) sel = 3'(k - 1);
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        valid_nxt = valid;
        clr       = '0;
`ifdef ROUND_ROBIN_EN
        ptr_nxt   = ptr;
`endif
        unique case (state)
            IDLE: begin
                if (Enable && (pending != '0)) begin
                    idx_nxt   = sel;
                    valid_nxt = 1'b1;
                    state_nxt = GRANT;
                end else begin
                    valid_nxt = 1'b0;
                end
            end
            GRANT: begin
                if (ack) begin
                    clr       = 8'b1 << idx;
                    valid_nxt = 1'b0;
                    state_nxt = IDLE;
`ifdef ROUND_ROBIN_EN
                    ptr_nxt   = idx;
`endif
                end
            end
        endcase
        // Capture is applied after the clear so a same-edge re-request survives.
        pending_nxt = (pending & ~clr) | (Enable ? req : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            valid   <= 1'b0;
            pending <= '0;
`ifdef ROUND_ROBIN_EN
            ptr     <= 3'd7;
`endif
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            valid   <= valid_nxt;
            pending <= pending_nxt;
`ifdef ROUND_ROBIN_EN
            ptr     <= ptr_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_pending_encoder8x3.sv
// Scoreboard bench for pending_encoder8x3: directed scenarios plus random traffic
// checked against a behavioural model of the grant/ack protocol.
module tb_pending_encoder8x3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       Enable;
    logic [7:0] req;
    logic       ack;
    logic [2:0] idx;
    logic       valid;
    logic [7:0] pending;

    pending_encoder8x3 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .Enable  (Enable),
        .req     (req),
        .ack     (ack),
        .idx     (idx),
        .valid   (valid),
        .pending (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit [7:0] p;
        bit       v;
        bit [2:0] i;
    } exp_t;

    exp_t exp_q[$];
    int   grant_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Behavioural model: set of pending sources, current grant, last granted source.
    bit [7:0] m_pend;
    bit       m_valid;
    int       m_idx;
    int       m_last;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic int pick(input bit [7:0] p, input int last);
`ifdef ROUND_ROBIN_EN
        for (int n = 1; n <= 8; n++)
            if (p[(last + n) % 8]) return (last + n) % 8;
`else
        for (int n = 0; n < 8; n++)
            if (p[n]) return n;
`endif
        return 0;
    endfunction

    task automatic model_reset();
        m_pend  = '0;
        m_valid = 1'b0;
        m_idx   = 0;
        m_last  = 7;
    endtask

    task automatic model_step(input bit en, input bit [7:0] r, input bit a);
        bit [7:0] np;
        exp_t     e;
        np = m_pend;
        if (m_valid) begin
            if (a) begin
                np[m_idx] = 1'b0;
                m_valid   = 1'b0;
                m_last    = m_idx;
            end
        end else if (en && m_pend != 0) begin
            m_idx   = pick(m_pend, m_last);
            m_valid = 1'b1;
            grant_q.push_back(m_idx);
        end
        if (en) np = np | r;
        m_pend = np;
        e.p = m_pend;
        e.v = m_valid;
        e.i = 3'(m_idx);
        exp_q.push_back(e);
    endtask

    // Drive at a falling edge, then advance to the next falling edge.
    task automatic step(input bit en, input bit [7:0] r, input bit a);
        Enable = en;
        req    = r;
        ack    = a;
        model_step(en, r, a);
        @(negedge clk);
    endtask

    task automatic async_reset();
        Enable = 1'b0;
        req    = '0;
        ack    = 1'b0;
        model_step(1'b0, 8'h00, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", valid, 0);
        chk("async_rst_idx", idx, 0);
        chk("async_rst_pending", pending, 0);
        #1 rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    // Monitor: per-edge state comparison plus grant order on every rising valid.
    logic mon_pv = 1'b0;
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                mon_pv = 1'b0;
            end else begin
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("pending", pending, e.p);
                    chk("valid", valid, e.v);
                    chk("idx", idx, e.i);
                end
                if (valid && !mon_pv) begin
                    if (grant_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL grant_unexpected: got idx %0d expected no grant at %0t", idx, $time);
                    end else begin
                        chk("grant_order", idx, grant_q.pop_front());
                    end
                end
                mon_pv = valid;
            end
        end
    end

    int gi;

    initial begin
        rst_n  = 1'b0;
        Enable = 1'b0;
        req    = '0;
        ack    = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_valid", valid, 0);
        chk("reset_idx", idx, 0);
        chk("reset_pending", pending, 0);
        rst_n = 1'b1;

        // A0 one cycle: grant 5, ack leaves 80, then grant 7
        step(1, 8'hA0, 0);
        chk("a0_pending", pending, 8'hA0);
        chk("a0_novalid_yet", valid, 0);
        step(1, 8'h00, 0);
        chk("a0_valid", valid, 1);
        chk("a0_idx5", idx, 5);
        step(1, 8'h00, 1);
        chk("a0_after_ack", pending, 8'h80);
        chk("a0_ack_valid", valid, 0);
        step(1, 8'h00, 0);
        chk("a0_idx7", idx, 7);
        step(1, 8'h00, 1);

        // Ack and re-request of the same bit on one edge
        step(1, 8'h08, 0);
        step(1, 8'h00, 0);
        chk("rereq_idx3", idx, 3);
        step(1, 8'h08, 1);
        chk("rereq_pending", pending, 8'h08);
        step(1, 8'h00, 0);
        chk("rereq_valid", valid, 1);
        chk("rereq_idx", idx, 3);
        step(1, 8'h00, 1);

        // Enable low ignores requests
        for (int i = 0; i < 4; i++) begin
            step(0, 8'hFF, 0);
            chk("dis_pending", pending, 0);
            chk("dis_valid", valid, 0);
        end

        // 81 held with every grant acked
        async_reset();
        step(1, 8'h81, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 8'h81, 0);
`ifdef ROUND_ROBIN_EN
            gi = (i % 2 == 0) ? 0 : 7;
`else
            gi = 0;
`endif
            chk("hold81_idx", idx, gi);
            step(1, 8'h81, 1);
        end

        // Asynchronous reset during a grant of 6
        async_reset();
        step(1, 8'h40, 0);
        step(1, 8'h00, 0);
        chk("g6_idx", idx, 6);
        async_reset();

        // Ack in IDLE has no effect
        for (int i = 0; i < 3; i++) step(1, 8'h00, 1);
        chk("idle_ack_valid", valid, 0);
        step(1, 8'h04, 0);
        step(1, 8'h00, 0);
        chk("idle_ack_idx2", idx, 2);
        step(1, 8'h00, 1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) async_reset();
            else step(($urandom_range(0, 3) != 0), 8'($urandom & $urandom & $urandom),
                      ($urandom_range(0, 2) == 0));
        end

        step(0, 8'h00, 0);
        step(0, 8'h00, 0);
        chk("exp_q_drained", exp_q.size(), 0);
        chk("grant_q_drained", grant_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
